// File: rtl/demux1x2_8bits_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux1x2_8bits_if : interleaved byte stream in, two lane words out   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface demux1x2_8bits_if #(
   parameter int BW = 8
);
   logic [BW-1:0] data_000;
   logic          valid_000;
   logic [BW-1:0] data_00;
   logic          valid_00;
   logic [BW-1:0] data_11;
   logic          valid_11;
   logic          out_stb;
   logic          locked;

   // master drives the serial stream and observes the lanes
   modport master (
      output data_000, valid_000,
      input  data_00, valid_00, data_11, valid_11, out_stb, locked
   );

   modport slave (
      input  data_000, valid_000,
      output data_00, valid_00, data_11, valid_11, out_stb, locked
   );
endinterface
`default_nettype wire

// File: rtl/demux1x2_8bits.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux1x2_8bits : splits a 4f interleaved byte stream into two lanes  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module demux1x2_8bits #(
   parameter int BW         = 8,
   parameter int IDLE_LIMIT = 8,
   parameter int CNT_W      = 4
) (
   input  wire                    clk_4f,
   input  wire                    reset,
   demux1x2_8bits_if.slave        bus
);

   localparam logic [CNT_W-1:0] C_IDLE_LAST = CNT_W'(IDLE_LIMIT - 1);
   localparam logic [CNT_W-1:0] C_IDLE_MAX  = CNT_W'(IDLE_LIMIT);

   logic [BW-1:0]    data_00_r;
   logic             valid_00_r;
   logic [BW-1:0]    data_11_r;
   logic             valid_11_r;
   logic             out_stb_r;
   logic             locked_r;
   logic             phase;
   logic [BW-1:0]    stage_data;
   logic             stage_valid;
   logic [CNT_W-1:0] idle_cnt;
   logic             unlock;

   // The IDLE_LIMIT-th consecutive idle sample drops alignment.
   assign unlock = locked_r && !bus.valid_000 && (idle_cnt == C_IDLE_LAST);

   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         data_00_r   <= '0;
         valid_00_r  <= 1'b0;
         data_11_r   <= '0;
         valid_11_r  <= 1'b0;
         out_stb_r   <= 1'b0;
         locked_r    <= 1'b0;
         phase       <= 1'b0;
         stage_data  <= '0;
         stage_valid <= 1'b0;
         idle_cnt    <= '0;
      end else begin
         out_stb_r <= 1'b0;
         if (!locked_r) begin
            if (bus.valid_000) begin
               locked_r    <= 1'b1;
               stage_data  <= bus.data_000;
               stage_valid <= 1'b1;
               phase       <= 1'b1;
               idle_cnt    <= '0;
            end
         end else if (unlock) begin
            // unlock takes priority over a coincident phase-1 update
            locked_r    <= 1'b0;
            phase       <= 1'b0;
            stage_valid <= 1'b0;
            valid_00_r  <= 1'b0;
            valid_11_r  <= 1'b0;
            idle_cnt    <= '0;
         end else begin
            phase <= ~phase;
            if (bus.valid_000) begin
               idle_cnt <= '0;
            end else if (idle_cnt != C_IDLE_MAX) begin
               idle_cnt <= idle_cnt + 1'b1;
            end
            if (!phase) begin
               stage_data  <= bus.data_000;
               stage_valid <= bus.valid_000;
            end else begin
               valid_00_r <= stage_valid;
               valid_11_r <= bus.valid_000;
               if (stage_valid) begin
                  data_00_r <= stage_data;
               end
               if (bus.valid_000) begin
                  data_11_r <= bus.data_000;
               end
               out_stb_r <= 1'b1;
            end
         end
      end
   end

   assign bus.data_00  = data_00_r;
   assign bus.valid_00 = valid_00_r;
   assign bus.data_11  = data_11_r;
   assign bus.valid_11 = valid_11_r;
   assign bus.out_stb  = out_stb_r;
   assign bus.locked   = locked_r;

endmodule
`default_nettype wire

// File: tb/tb_demux1x2_8bits.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_demux1x2_8bits : directed vector bench for demux1x2_8bits         |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_demux1x2_8bits;

   logic clk_4f = 1'b0;
   logic reset  = 1'b1;
   int   compared   = 0;
   int   mismatched = 0;

   demux1x2_8bits_if #(.BW(8)) bus ();

   demux1x2_8bits #(.BW(8), .IDLE_LIMIT(8), .CNT_W(4)) dut (
      .clk_4f (clk_4f),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 clk_4f = ~clk_4f;

   typedef struct {
      logic       vin;
      logic [7:0] din;
      logic [7:0] d00;
      logic       v00;
      logic [7:0] d11;
      logic       v11;
      logic       stb;
      logic       lck;
   } vec_t;

   vec_t tbl [26];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_4f);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [7:0] d00, input logic v00,
                            input logic [7:0] d11, input logic v11,
                            input logic stb, input logic lck);
      check({tag, ".data_00"},  bus.data_00, d00);
      check({tag, ".valid_00"}, {7'd0, bus.valid_00}, {7'd0, v00});
      check({tag, ".data_11"},  bus.data_11, d11);
      check({tag, ".valid_11"}, {7'd0, bus.valid_11}, {7'd0, v11});
      check({tag, ".out_stb"},  {7'd0, bus.out_stb}, {7'd0, stb});
      check({tag, ".locked"},   {7'd0, bus.locked}, {7'd0, lck});
   endtask

   initial begin
      // stream, hole, idle unlock from phase 0, realign, unlock on a phase-1 edge
      tbl[0]  = '{1'b1, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[1]  = '{1'b1, 8'h02, 8'h01, 1'b1, 8'h02, 1'b1, 1'b1, 1'b1};
      tbl[2]  = '{1'b1, 8'h03, 8'h01, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 8'h04, 8'h03, 1'b1, 8'h04, 1'b1, 1'b1, 1'b1};
      tbl[4]  = '{1'b1, 8'hA0, 8'h03, 1'b1, 8'h04, 1'b1, 1'b0, 1'b1};
      tbl[5]  = '{1'b0, 8'h77, 8'hA0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1};
      tbl[6]  = '{1'b1, 8'hB0, 8'hA0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 8'hEE, 8'hB0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1};
      tbl[8]  = '{1'b0, 8'hEE, 8'hB0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 8'hEE, 8'hB0, 1'b0, 8'h04, 1'b0, 1'b1, 1'b1};
      tbl[10] = '{1'b0, 8'hEE, 8'hB0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 8'hEE, 8'hB0, 1'b0, 8'h04, 1'b0, 1'b1, 1'b1};
      tbl[12] = '{1'b0, 8'hEE, 8'hB0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 8'hEE, 8'hB0, 1'b0, 8'h04, 1'b0, 1'b1, 1'b1};
      tbl[14] = '{1'b0, 8'hEE, 8'hB0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{1'b0, 8'hEE, 8'hB0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0};
      tbl[16] = '{1'b1, 8'h55, 8'hB0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b1};
      tbl[17] = '{1'b1, 8'hAA, 8'h55, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b1};
      tbl[18] = '{1'b0, 8'h3C, 8'h55, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b1};
      tbl[19] = '{1'b0, 8'h3C, 8'h55, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b1};
      tbl[20] = '{1'b0, 8'h3C, 8'h55, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b1};
      tbl[21] = '{1'b0, 8'h3C, 8'h55, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b1};
      tbl[22] = '{1'b0, 8'h3C, 8'h55, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b1};
      tbl[23] = '{1'b0, 8'h3C, 8'h55, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b1};
      tbl[24] = '{1'b0, 8'h3C, 8'h55, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b1};
      tbl[25] = '{1'b0, 8'h3C, 8'h55, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0};

      bus.data_000  = 8'h00;
      bus.valid_000 = 1'b0;

      // reset held from time zero, then released between edges
      #2;
      check_all("reset0", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_unlocked.locked", {7'd0, bus.locked}, 8'h00);
         check("idle_unlocked.out_stb", {7'd0, bus.out_stb}, 8'h00);
      end

      for (int i = 0; i < 26; i++) begin
         bus.valid_000 = tbl[i].vin;
         bus.data_000  = tbl[i].din;
         tick();
         check_all($sformatf("vec%0d", i), tbl[i].d00, tbl[i].v00,
                   tbl[i].d11, tbl[i].v11, tbl[i].stb, tbl[i].lck);
      end

      // reset between the phase-0 capture of 0xFF and its phase-1 partner
      bus.valid_000 = 1'b1;
      bus.data_000  = 8'hFF;
      tick();
      check("midpair.locked_before", {7'd0, bus.locked}, 8'h01);
      #2;
      reset = 1'b1;
      #1;
      check_all("midpair_async", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      bus.valid_000 = 1'b0;
      tick();
      reset = 1'b0;
      bus.valid_000 = 1'b1;
      bus.data_000  = 8'h00;
      tick();
      check_all("post_reset0", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      bus.data_000  = 8'h11;
      tick();
      check_all("post_reset1", 8'h00, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1);
      bus.valid_000 = 1'b0;
      tick();
      check_all("post_reset2", 8'h00, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
